// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between fetch (0) and load/store (1).
// Optional ack watchdog enabled by defining ARB_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req0_i,
  input  logic [WIDTH-1:0] addr0_i,
  input  logic             req1_i,
  input  logic [WIDTH-1:0] addr1_i,
  input  logic             we1_i,
  input  logic [WIDTH-1:0] wdata1_i,
  output logic             mem_req_o,
  output logic [WIDTH-1:0] mem_addr_o,
  output logic             mem_we_o,
  output logic [WIDTH-1:0] mem_wdata_o,
  input  logic             mem_ack_i,
  input  logic [WIDTH-1:0] mem_rdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             ack0_o,
  output logic             ack1_o,
  output logic             sel_o,
  output logic             err_o
);

  typedef enum logic [1:0] {IDLE, BUSY0, BUSY1} state_t;

  state_t state_q, state_d;
  logic   last_q, last_d;
  logic   sel_q, sel_d;
  logic   busy;
  logic   timeout;

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT) + 1;
  logic [CW-1:0] cnt_q, cnt_d;
`endif

  assign busy = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    sel_d   = sel_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    timeout = busy && !mem_ack_i && (cnt_q == CW'(TIMEOUT - 1));
`else
    timeout = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        // On a tie the requester that did not win last time gets the port.
        if (req0_i && (!req1_i || last_q)) begin
          state_d = BUSY0;
          last_d  = 1'b0;
          sel_d   = 1'b0;
`ifdef ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end else if (req1_i) begin
          state_d = BUSY1;
          last_d  = 1'b1;
          sel_d   = 1'b1;
`ifdef ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      BUSY0, BUSY1: begin
        if (mem_ack_i || timeout) begin
          state_d = IDLE;
        end else begin
`ifdef ARB_TIMEOUT_EN
          cnt_d = cnt_q + CW'(1);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      sel_q   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign mem_req_o   = busy;
  assign sel_o       = sel_q;
  assign mem_addr_o  = sel_q ? addr1_i : addr0_i;
  assign mem_we_o    = (state_q == BUSY1) && we1_i;
  assign mem_wdata_o = wdata1_i;
  assign rdata_o     = mem_rdata_i;
  assign ack0_o      = (state_q == BUSY0) && mem_ack_i;
  assign ack1_o      = (state_q == BUSY1) && mem_ack_i;
  assign err_o       = timeout;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed plus randomized bench for mem_port_arbiter against a transaction-level model.
module tb_mem_port_arbiter;
  localparam int W  = 32;
  localparam int TO = 4;

  logic         clk = 1'b0;
  logic         rst, r0, r1, we1, mack;
  logic [W-1:0] a0, a1, wd1, mrd;
  logic         mreq, mwe, ack0, ack1, sel, err;
  logic [W-1:0] maddr, mwdata, rdata;

  int checks = 0;
  int errors = 0;

  // Reference model: owner 0 = none, 1 = fetch, 2 = load/store
  int owner = 0;
  bit m_last = 1'b1;
  bit m_sel = 1'b0;
  int m_cnt = 0;
  bit ev_ack0, ev_ack1;

  always #5 clk = ~clk;

  mem_port_arbiter #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst),
    .req0_i(r0), .addr0_i(a0),
    .req1_i(r1), .addr1_i(a1), .we1_i(we1), .wdata1_i(wd1),
    .mem_req_o(mreq), .mem_addr_o(maddr), .mem_we_o(mwe), .mem_wdata_o(mwdata),
    .mem_ack_i(mack), .mem_rdata_i(mrd), .rdata_o(rdata),
    .ack0_o(ack0), .ack1_o(ack1), .sel_o(sel), .err_o(err)
  );

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit m_timeout();
`ifdef ARB_TIMEOUT_EN
    return (owner != 0) && !mack && (m_cnt == TO - 1);
`else
    return 1'b0;
`endif
  endfunction

  // Wait to the falling edge and compare every output against the model.
  task automatic sample(input bit do_chk);
    @(negedge clk);
    if (do_chk) begin
      chk("mem_req", W'(mreq), W'(owner != 0));
      chk("sel", W'(sel), W'(m_sel));
      chk("mem_addr", maddr, m_sel ? a1 : a0);
      chk("mem_we", W'(mwe), W'((owner == 2) && we1));
      chk("mem_wdata", mwdata, wd1);
      chk("rdata", rdata, mrd);
      chk("ack0", W'(ack0), W'((owner == 1) && mack));
      chk("ack1", W'(ack1), W'((owner == 2) && mack));
      chk("err", W'(err), W'(m_timeout()));
    end
  endtask

  // Apply the arbitration rules to the model, then move to the next cycle.
  task automatic advance();
    bit to;
    to = m_timeout();
    ev_ack0 = (owner == 1) && mack;
    ev_ack1 = (owner == 2) && mack;
    if (rst) begin
      owner = 0; m_last = 1'b1; m_sel = 1'b0; m_cnt = 0;
    end else if (owner == 0) begin
      if (r0 || r1) begin
        int g;
        g = (r0 && r1) ? int'(!m_last) : (r0 ? 0 : 1);
        owner = g + 1; m_last = bit'(g); m_sel = bit'(g); m_cnt = 0;
      end
    end else if (mack || to) begin
      owner = 0;
    end else begin
      m_cnt++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    sample(1'b1);
    advance();
  endtask

  task automatic do_reset();
    rst = 1'b1; r0 = 1'b0; r1 = 1'b0; mack = 1'b0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    bit p0, p1;
    int k;
    rst = 1'b1; r0 = 0; r1 = 0; we1 = 0; mack = 0;
    a0 = '0; a1 = '0; wd1 = '0; mrd = '0;
    sample(1'b0);
    advance();
    step();
    rst = 1'b0;
    $display("reset: mem_req=%0b sel=%0b ack0=%0b ack1=%0b", mreq, sel, ack0, ack1);

    // Single fetch with read data
    r0 = 1; a0 = 32'h0000_0100;
    step();
    sample(1'b1);
    chk("fetch_req", W'(mreq), W'(1));
    chk("fetch_addr", maddr, 32'h100);
    advance();
    mack = 1; mrd = 32'hDEAD_BEEF;
    sample(1'b1);
    chk("fetch_ack0", W'(ack0), W'(1));
    chk("fetch_rdata", rdata, 32'hDEAD_BEEF);
    chk("fetch_ack1", W'(ack1), W'(0));
    advance();
    r0 = 0; mack = 0;
    step();
    $display("fetch: addr=%h rdata=%h", a0, mrd);

    // Sustained contention after reset: 0,1,0,1 with a bubble between grants
    do_reset();
    r0 = 1; r1 = 1; a0 = 32'hA0; a1 = 32'hB0;
    k = 0;
    for (int c = 0; c < 12; c++) begin
      mack = (owner != 0);
      sample(1'b1);
      if (owner != 0) begin
        chk("rr_order", W'(sel), W'(k % 2));
        $display("rr grant %0d: sel=%0b", k, sel);
        k++;
      end
      advance();
    end
    r0 = 0; r1 = 0; mack = 0;
    step();

    // Store through requester 1, then fetch with we1 still high
    do_reset();
    r1 = 1; we1 = 1; a1 = 32'h2000; wd1 = 32'h1234_5678;
    step();
    mack = 1;
    sample(1'b1);
    chk("store_we", W'(mwe), W'(1));
    chk("store_addr", maddr, 32'h2000);
    chk("store_wdata", mwdata, 32'h1234_5678);
    advance();
    r1 = 0; mack = 0; r0 = 1; a0 = 32'h300;
    step();
    step();
    mack = 1;
    sample(1'b1);
    chk("fetch_we_low", W'(mwe), W'(0));
    advance();
    r0 = 0; we1 = 0; mack = 0;
    step();
    $display("store: addr=%h wdata=%h", a1, wd1);

    // Reset mid BUSY1, stale ack, then a tie must go to fetch
    do_reset();
    r1 = 1;
    step();
    step();
    rst = 1;
    step();
    rst = 0; r1 = 0; mack = 1;
    sample(1'b1);
    chk("stale_ack0", W'(ack0), W'(0));
    chk("stale_ack1", W'(ack1), W'(0));
    chk("stale_idle", W'(mreq), W'(0));
    advance();
    mack = 0; r0 = 1; r1 = 1;
    step();
    sample(1'b1);
    chk("post_rst_sel", W'(sel), W'(0));
    chk("post_rst_req", W'(mreq), W'(1));
    advance();
    mack = 1;
    step();
    r0 = 0; r1 = 0; mack = 0;
    step();
    $display("reset mid-transaction: grant after reset sel=0");

`ifdef ARB_TIMEOUT_EN
    // Watchdog abort, then an ack on the final cycle wins
    do_reset();
    r0 = 1;
    step();
    for (int c = 0; c < 3; c++) step();
    sample(1'b1);
    chk("to_err", W'(err), W'(1));
    chk("to_ack0", W'(ack0), W'(0));
    advance();
    sample(1'b1);
    chk("to_idle", W'(mreq), W'(0));
    advance();
    for (int c = 0; c < 3; c++) step();
    mack = 1;
    sample(1'b1);
    chk("to_late_ack0", W'(ack0), W'(1));
    chk("to_late_err", W'(err), W'(0));
    advance();
    r0 = 0; mack = 0;
    step();
    $display("timeout: abort and ack-precedence exercised");
`endif

    // Randomized traffic honouring the hold-until-ack protocol
    do_reset();
    p0 = 0; p1 = 0;
    for (int c = 0; c < 400; c++) begin
      if (!p0 && ($urandom_range(0, 2) == 0)) begin p0 = 1; a0 = $urandom; end
      if (!p1 && ($urandom_range(0, 2) == 0)) begin
        p1 = 1; a1 = $urandom; wd1 = $urandom; we1 = 1'($urandom);
      end
      r0 = p0; r1 = p1;
      mack = (owner != 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
      mrd = $urandom;
      step();
      if (ev_ack0) begin p0 = 0; $display("rand cycle %0d: ack0", c); end
      if (ev_ack1) begin p1 = 0; $display("rand cycle %0d: ack1", c); end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester controller that shares the core's single memory port between instruction fetch (requester 0) and load/store (requester 1). It arbitrates round-robin, holds the grant for one complete request/acknowledge transaction, and drives the select line of the 2-input address/write-data muxes in front of the port. The read data is broadcast to both requesters, and only the granted requester sees its acknowledge pulse.

## Interface
Parameters:
- `WIDTH`, 32: address and data width.
- `TIMEOUT`, 16: cycles to wait for `mem_ack_i` before aborting. Used only with `ARB_TIMEOUT_EN`. Must be ≥ 2.

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset; synchronous, active-high.
- `req0_i`  in  1  fetch request; held with `addr0_i` until `ack0_o`.
- `addr0_i`  in  WIDTH  fetch address.
- `req1_i`  in  1  load/store request; held with `addr1_i`/`we1_i`/`wdata1_i` until `ack1_o`.
- `addr1_i`  in  WIDTH  load/store address.
- `we1_i`  in  1  write enable of requester 1.
- `wdata1_i`  in  WIDTH  store data.
- `mem_req_o`  out  1  memory request strobe.
- `mem_addr_o`  out  WIDTH  `sel_o ? addr1_i : addr0_i`.
- `mem_we_o`  out  1  `we1_i` when granted to 1 and busy, else 0.
- `mem_wdata_o`  out  WIDTH  `wdata1_i`.
- `mem_ack_i`  in  1  memory completion, single-cycle pulse.
- `mem_rdata_i`  in  WIDTH  read data, valid with `mem_ack_i`.
- `rdata_o`  out  WIDTH  `mem_rdata_i` passed through.
- `ack0_o`  out  1  completion pulse to fetch.
- `ack1_o`  out  1  completion pulse to load/store.
- `sel_o`  out  1  mux select / current owner (0 = fetch, 1 = load/store).
- `err_o`  out  1  timeout abort pulse (constant 0 without `ARB_TIMEOUT_EN`).

## Operation
- FSM states:
  - IDLE: reset state.
  - BUSY0: granted to requester 0.
  - BUSY1: granted to requester 1.
- IDLE transitions:
  - Only `req0_i` → BUSY0. Only `req1_i` → BUSY1.
  - Both requests → the requester other than `last` (1-bit register of the most recent grant, reset value 1). Fetch therefore wins the first tie after reset.
  - No request → stay in IDLE.
- Entering BUSYn loads `last` ← n and sets `sel_o` = n.
- `sel_o` is registered and changes only on the IDLE → BUSY edge. It holds its value through IDLE.
- BUSYn:
  - `mem_req_o` = 1.
  - `ackn_o` = `mem_ack_i` (combinational).
  - On `mem_ack_i`, go to IDLE.
- `mem_ack_i` in IDLE is ignored; no ack output fires.
- A requester dropping `req` before its ack is a protocol violation. The block ignores it and completes the transaction.
- `rst_i`, including mid-transaction: state IDLE, `last` = 1, `sel_o` = 0, timeout counter 0. All outputs are 0 except the pass-through data paths.

## Timing
- Request seen in IDLE at cycle N → `mem_req_o`/`sel_o` valid at N+1.
- `mem_ack_i` at cycle M → `ackn_o` at M (zero latency) → IDLE at M+1.
- Earliest next grant is M+2, so there is one mandatory idle bubble between transactions.
- Minimum transaction: request at N, ack at N+1, next grant at N+3.
- Sustained contention alternates 0,1,0,1 with no starvation.
- The `ack0_o`/`ack1_o` outputs are one-hot or zero, never both.

## Configuration
- `ARB_TIMEOUT_EN` defined:
  - A counter clears on entry to BUSYn and increments each BUSY cycle without `mem_ack_i`.
  - On the cycle the count reaches `TIMEOUT`-1 with no ack: `err_o` pulses for one cycle, no `ackn_o` fires, the FSM goes to IDLE, and `last` keeps the aborted owner.
  - An ack arriving on that same cycle takes precedence: normal completion, no `err_o`.
- `ARB_TIMEOUT_EN` undefined: no counter, `err_o` tied to 0, BUSY waits indefinitely.

## Test plan
- Reset, then `req0_i`=1, `addr0_i`=0x0000_0100. Expect `mem_req_o`=1, `sel_o`=0, `mem_addr_o`=0x100 at the next cycle. Drive ack with `mem_rdata_i`=0xDEAD_BEEF: `ack0_o`=1 and `rdata_o`=0xDEADBEEF in the same cycle, `ack1_o`=0.
- Both requests held, ack one cycle after each grant. Expect grant order 0,1,0,1, with `sel_o` toggling each transaction and an idle bubble between them.
- `req1_i`=1, `we1_i`=1, `addr1_i`=0x2000, `wdata1_i`=0x1234_5678. Expect `mem_we_o`=1, `mem_addr_o`=0x2000, `mem_wdata_o`=0x12345678. With only `req0_i` active, `mem_we_o`=0 even if `we1_i`=1.
- Assert `rst_i` mid-BUSY1, then pulse a stale `mem_ack_i`. Expect no ack output, IDLE state, and on simultaneous requests the grant goes to 0.
- `ARB_TIMEOUT_EN`, `TIMEOUT`=4, never ack. Expect `err_o` pulse 4 cycles after the grant, then return to IDLE, no `ack0_o`. Ack on the 4th cycle → `ack0_o`=1, `err_o`=0.
